// File: rtl/mem_pkg.sv
// Shared memory geometry defaults and arbiter state encoding, so the memory
// instance and its port arbiter always agree on width, address and depth.
package mem_pkg;

    localparam int MEM_WIDTH = 32;
    localparam int MEM_ADDR  = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after the last winner, wrapping, as one-hot plus index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single-port synchronous memory, with a software
// triggered sweep that writes zeros to every address.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = MEM_WIDTH,
    parameter int ADDR  = MEM_ADDR,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [WIDTH-1:0]      rdata,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_rst,
    output logic [ADDR-1:0]       mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_wrbar,
    input  logic [WIDTH-1:0]      mem_rdata
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR-1:0] CLR_LAST = ADDR'(DEPTH - 1);
    localparam logic [IDXW-1:0] RR_INIT  = IDXW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] rr_last_q, rr_last_d;
    logic [ADDR-1:0] clr_cnt_q, clr_cnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic            clr_done_q, clr_done_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req  (req),
        .last (rr_last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        clr_cnt_d  = clr_cnt_q;
        rvalid_d   = '0;
        clr_done_d = 1'b0;
        gnt        = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wrbar  = 1'b0;

        if (state_q == ARB) begin
            if (pick_any) begin
                gnt       = pick_gnt;
                mem_addr  = req_addr[int'(pick_idx)*ADDR +: ADDR];
                mem_wdata = req_wdata[int'(pick_idx)*WIDTH +: WIDTH];
                mem_wrbar = req_we[pick_idx];
                rr_last_d = pick_idx;
                rvalid_d  = pick_gnt & ~req_we;
            end
            // The access granted alongside a clear request still commits.
            if (clr_req) begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        end else begin
            mem_addr  = clr_cnt_q;
            mem_wrbar = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            // Terminal compare on DEPTH-1 so a depth below 2**ADDR still stops.
            if (clr_cnt_q == CLR_LAST) begin
                state_d    = ARB;
                clr_cnt_d  = '0;
                clr_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_last_q  <= RR_INIT;
            clr_cnt_q  <= '0;
            rvalid_q   <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            clr_cnt_q  <= clr_cnt_d;
            rvalid_q   <= rvalid_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign rvalid   = rvalid_q;
    assign rdata    = mem_rdata;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign mem_rst  = ~rst_n;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter driving a behavioural single-port memory.
module tb_mem_port_arbiter;

    localparam int NREQ = 4, WIDTH = 32, ADDR = 8, DEPTH = 256;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req, req_we, gnt, rvalid;
    logic [NREQ*ADDR-1:0]  req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [WIDTH-1:0]      rdata, mem_wdata, mem_rdata;
    logic                  clr_req, clr_busy, clr_done, mem_rst, mem_wrbar;
    logic [ADDR-1:0]       mem_addr;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .mem_rst(mem_rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrbar(mem_wrbar),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory with active-high clear; read returns pre-write data.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wrbar) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]   req, we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   gnt, rvalid;
        logic [31:0]  rdata;
        logic         wrbar;
        logic [7:0]   maddr;
        logic [31:0]  mwdata;
    } vec_t;

    vec_t v[16];

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] we, logic [31:0] ad,
                                logic [127:0] wd, logic [3:0] g, logic [3:0] rv,
                                logic [31:0] rd, logic wr, logic [7:0] ma, logic [31:0] mw);
        vec_t t;
        t.req = rq; t.we = we; t.addr = ad; t.wdata = wd; t.gnt = g; t.rvalid = rv;
        t.rdata = rd; t.wrbar = wr; t.maddr = ma; t.mwdata = mw;
        return t;
    endfunction

    localparam logic [31:0]  ADDRS = {8'h03, 8'h02, 8'h01, 8'h00};
    localparam logic [31:0]  A10_1 = {8'h00, 8'h00, 8'h10, 8'h00};
    localparam logic [31:0]  A10_2 = {8'h00, 8'h10, 8'h00, 8'h00};
    localparam logic [31:0]  A10_A = {8'h10, 8'h10, 8'h10, 8'h10};
    localparam logic [127:0] WDB   = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    localparam logic [127:0] WD    = {32'hA0A00003, 32'hA0A00002, 32'hA0A00001, 32'hA0A00000};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] we,
                         input logic [31:0] ad, input logic [127:0] wd, input logic cr);
        @(negedge clk);
        req = rq; req_we = we; req_addr = ad; req_wdata = wd; clr_req = cr;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; clr_req = 1'b0;

        v[0]  = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 4'b0000, 32'h0,        1'b0, 8'h00, 32'h0);
        v[1]  = mk(4'b0010, 4'b0010, A10_1, WDB,    4'b0010, 4'b0000, 32'h0,        1'b1, 8'h10, 32'hDEADBEEF);
        v[2]  = mk(4'b0010, 4'b0000, A10_1, 128'h0, 4'b0010, 4'b0000, 32'h0,        1'b0, 8'h10, 32'h0);
        v[3]  = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 4'b0010, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0);
        v[4]  = mk(4'b1111, 4'b1111, ADDRS, WD,     4'b0100, 4'b0000, 32'h0,        1'b1, 8'h02, 32'hA0A00002);
        v[5]  = mk(4'b1111, 4'b1111, ADDRS, WD,     4'b1000, 4'b0000, 32'h0,        1'b1, 8'h03, 32'hA0A00003);
        v[6]  = mk(4'b1111, 4'b1111, ADDRS, WD,     4'b0001, 4'b0000, 32'h0,        1'b1, 8'h00, 32'hA0A00000);
        v[7]  = mk(4'b1111, 4'b1111, ADDRS, WD,     4'b0010, 4'b0000, 32'h0,        1'b1, 8'h01, 32'hA0A00001);
        v[8]  = mk(4'b1111, 4'b0000, ADDRS, 128'h0, 4'b0100, 4'b0000, 32'h0,        1'b0, 8'h02, 32'h0);
        v[9]  = mk(4'b1111, 4'b0000, ADDRS, 128'h0, 4'b1000, 4'b0100, 32'hA0A00002, 1'b0, 8'h03, 32'h0);
        v[10] = mk(4'b1111, 4'b0000, ADDRS, 128'h0, 4'b0001, 4'b1000, 32'hA0A00003, 1'b0, 8'h00, 32'h0);
        v[11] = mk(4'b1111, 4'b0000, ADDRS, 128'h0, 4'b0010, 4'b0001, 32'hA0A00000, 1'b0, 8'h01, 32'h0);
        v[12] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 4'b0010, 32'hA0A00001, 1'b0, 8'h00, 32'h0);
        v[13] = mk(4'b1000, 4'b0000, ADDRS, 128'h0, 4'b1000, 4'b0000, 32'h0,        1'b0, 8'h03, 32'h0);
        v[14] = mk(4'b1000, 4'b0000, ADDRS, 128'h0, 4'b1000, 4'b1000, 32'hA0A00003, 1'b0, 8'h03, 32'h0);
        v[15] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 4'b1000, 32'hA0A00003, 1'b0, 8'h00, 32'h0);

        // Reset and idle
        step();
        chk("rst_mem_rst", 32'(mem_rst), 32'd1);
        step(); step();
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_mem_rst", 32'(mem_rst), 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(v[i].req, v[i].we, v[i].addr, v[i].wdata, 1'b0);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v[i].rvalid));
            if (v[i].rvalid != 0) chk($sformatf("v%0d_rdata", i), rdata, v[i].rdata);
            chk($sformatf("v%0d_wrbar", i), 32'(mem_wrbar), 32'(v[i].wrbar));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(v[i].maddr));
            chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].mwdata);
            chk($sformatf("v%0d_busy", i), 32'(clr_busy), 32'd0);
        end

        // Clear requested while requester 2 reads 0x10; second pulse mid-sweep is ignored
        drive(4'b0100, 4'b0000, A10_2, 128'h0, 1'b1);
        chk("clr_req_gnt", 32'(gnt), 32'b0100);
        chk("clr_req_busy", 32'(clr_busy), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(4'b1111, 4'b0000, ADDRS, 128'h0, k == 50);
            chk($sformatf("clr%0d_busy", k), 32'(clr_busy), 32'd1);
            chk($sformatf("clr%0d_addr", k), 32'(mem_addr), k);
            chk($sformatf("clr%0d_wrbar", k), 32'(mem_wrbar), 32'd1);
            chk($sformatf("clr%0d_wdata", k), mem_wdata, 32'h0);
            chk($sformatf("clr%0d_gnt", k), 32'(gnt), 32'd0);
            chk($sformatf("clr%0d_done", k), 32'(clr_done), 32'd0);
            chk($sformatf("clr%0d_rvalid", k), 32'(rvalid), (k == 0) ? 32'b0100 : 32'd0);
            if (k == 0) chk("clr_prior_rdata", rdata, 32'hDEADBEEF);
        end
        drive(4'b1111, 4'b0000, A10_A, 128'h0, 1'b0);
        chk("clr_done_pulse", 32'(clr_done), 32'd1);
        chk("clr_end_busy", 32'(clr_busy), 32'd0);
        chk("clr_end_gnt", 32'(gnt), 32'b1000);
        chk("clr_end_addr", 32'(mem_addr), 32'h10);
        drive(4'b0000, 4'b0000, 32'h0, 128'h0, 1'b0);
        chk("clr_done_once", 32'(clr_done), 32'd0);
        chk("clr_rd_rvalid", 32'(rvalid), 32'b1000);
        chk("clr_rd_zero", rdata, 32'h0);
        for (int k = 0; k < 300; k++) begin
            step();
            chk("no_extra_done", 32'(clr_done), 32'd0);
        end

        // Reset at clear cycle 100 aborts the sweep and restarts round-robin at 0
        drive(4'b0000, 4'b0000, 32'h0, 128'h0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            drive(4'b0000, 4'b0000, 32'h0, 128'h0, 1'b0);
            if (k == 99) chk("mid_busy", 32'(clr_busy), 32'd1);
        end
        @(negedge clk); rst_n = 1'b0; #1;
        chk("mid_rst_mem_rst", 32'(mem_rst), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        req = 4'b1111; req_we = 4'b0000; req_addr = ADDRS; #1;
        chk("post_rst_busy", 32'(clr_busy), 32'd0);
        chk("post_rst_done", 32'(clr_done), 32'd0);
        chk("post_rst_gnt0", 32'(gnt), 32'b0001);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_rvalid", k), 32'(rvalid), 32'(4'b0001 << ((k - 1) % 4)));
            chk($sformatf("rr%0d_rdata", k), rdata, 32'h0);
            chk($sformatf("rr%0d_done", k), 32'(clr_done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
